// File: rtl/red_pair_stage.sv
// Two-stage RED front end: stage 1 forms four signed nibble-lane sums,
// stage 2 folds them into signed hi/lo pair sums for the final RED adder.
module red_pair_stage #(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             stall,
   input  logic             flush,
   input  logic [15:0]      A,
   input  logic [15:0]      B,
   input  logic [TAG_W-1:0] rd_in,
   output logic             in_ready,
   output logic             out_valid,
   output logic [5:0]       pair_hi,
   output logic [5:0]       pair_lo,
   output logic [TAG_W-1:0] rd_out
);

   logic [3:0][4:0]  s1_sum_d, s1_sum_q;
   logic [TAG_W-1:0] s1_tag_d, s1_tag_q;
   logic             s1_valid_d, s1_valid_q;
   logic [5:0]       pair_hi_d, pair_hi_q;
   logic [5:0]       pair_lo_d, pair_lo_q;
   logic [TAG_W-1:0] rd_out_d, rd_out_q;
   logic             out_valid_d, out_valid_q;

   assign in_ready = ~stall;

   always_comb begin
      s1_sum_d  = s1_sum_q;
      s1_tag_d  = s1_tag_q;
      pair_hi_d = pair_hi_q;
      pair_lo_d = pair_lo_q;
      rd_out_d  = rd_out_q;
      if (!stall) begin
         for (int k = 0; k < 4; k++) begin
            s1_sum_d[k] = {A[4*k+3], A[4*k +: 4]} + {B[4*k+3], B[4*k +: 4]};
         end
         s1_tag_d  = rd_in;
         pair_hi_d = {s1_sum_q[3][4], s1_sum_q[3]} + {s1_sum_q[2][4], s1_sum_q[2]};
         pair_lo_d = {s1_sum_q[1][4], s1_sum_q[1]} + {s1_sum_q[0][4], s1_sum_q[0]};
         rd_out_d  = s1_tag_q;
      end
   end

   // Flush beats stall so in-flight ops die even while the pipe is frozen.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
      end else if (!stall) begin
         s1_valid_d  = in_valid;
         out_valid_d = s1_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_sum_q    <= '0;
         s1_tag_q    <= '0;
         s1_valid_q  <= 1'b0;
         pair_hi_q   <= '0;
         pair_lo_q   <= '0;
         rd_out_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         s1_sum_q    <= s1_sum_d;
         s1_tag_q    <= s1_tag_d;
         s1_valid_q  <= s1_valid_d;
         pair_hi_q   <= pair_hi_d;
         pair_lo_q   <= pair_lo_d;
         rd_out_q    <= rd_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign pair_hi   = pair_hi_q;
   assign pair_lo   = pair_lo_q;
   assign rd_out    = rd_out_q;

endmodule

// File: tb/tb_red_pair_stage.sv
// Directed and random checks of red_pair_stage: latency, stall, flush, reset.
module tb_red_pair_stage;

   localparam int unsigned TAG_W = 4;
   localparam int NRAND = 200;

   logic             clk = 1'b0;
   logic             rst_n, in_valid, stall, flush;
   logic [15:0]      A, B;
   logic [TAG_W-1:0] rd_in;
   logic             in_ready, out_valid;
   logic [5:0]       pair_hi, pair_lo;
   logic [TAG_W-1:0] rd_out;

   int n_checks = 0;
   int n_errors = 0;

   logic [11:0]      exp_pair [NRAND];
   logic [TAG_W-1:0] exp_tag  [NRAND];

   red_pair_stage #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .stall     (stall),
      .flush     (flush),
      .A         (A),
      .B         (B),
      .rd_in     (rd_in),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .pair_hi   (pair_hi),
      .pair_lo   (pair_lo),
      .rd_out    (rd_out)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Advance one clock edge; outputs are then sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [TAG_W-1:0] t);
      in_valid = v;
      A        = a;
      B        = b;
      rd_in    = t;
   endtask

   // Reference: exact signed lane sums, then pair sums, truncated to 6 bits.
   function automatic logic [11:0] model(input logic [15:0] a, input logic [15:0] b);
      int s [4];
      int hi, lo;
      logic [5:0] h6, l6;
      for (int k = 0; k < 4; k++) begin
         s[k] = int'($signed(a[4*k +: 4])) + int'($signed(b[4*k +: 4]));
      end
      hi = s[3] + s[2];
      lo = s[1] + s[0];
      h6 = hi[5:0];
      l6 = lo[5:0];
      return {h6, l6};
   endfunction

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      drive(1'b1, 16'h1234, 16'h5678, 4'd9);
      step();
      step();
      check_eq("rst_valid", 16'(out_valid), 16'd0);
      check_eq("rst_hi", 16'(pair_hi), 16'd0);
      check_eq("rst_lo", 16'(pair_lo), 16'd0);
      check_eq("rst_tag", 16'(rd_out), 16'd0);
      check_eq("ready_hi", 16'(in_ready), 16'd1);
      rst_n = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 4'd0);
      step();

      // Most negative lanes: -8 + -8 = -16 per lane, -32 per pair.
      drive(1'b1, 16'h8888, 16'h8888, 4'd1);
      step();
      drive(1'b0, 16'h0, 16'h0, 4'd0);
      check_eq("neg_early", 16'(out_valid), 16'd0);
      step();
      check_eq("neg_valid", 16'(out_valid), 16'd1);
      check_eq("neg_hi", 16'(pair_hi), 16'h20);
      check_eq("neg_lo", 16'(pair_lo), 16'h20);
      check_eq("neg_tag", 16'(rd_out), 16'd1);

      // Back-to-back: max positive (28), then 9+7 lanes -> 0.
      drive(1'b1, 16'h7777, 16'h7777, 4'd3);
      step();
      drive(1'b1, 16'h9999, 16'h7777, 4'd5);
      step();
      drive(1'b0, 16'h0, 16'h0, 4'd0);
      check_eq("b2b0_valid", 16'(out_valid), 16'd1);
      check_eq("b2b0_hi", 16'(pair_hi), 16'h1C);
      check_eq("b2b0_lo", 16'(pair_lo), 16'h1C);
      check_eq("b2b0_tag", 16'(rd_out), 16'd3);
      step();
      check_eq("b2b1_valid", 16'(out_valid), 16'd1);
      check_eq("b2b1_hi", 16'(pair_hi), 16'h00);
      check_eq("b2b1_lo", 16'(pair_lo), 16'h00);
      check_eq("b2b1_tag", 16'(rd_out), 16'd5);
      step();
      check_eq("bubble", 16'(out_valid), 16'd0);

      // Random full-throughput stream.
      for (int i = 0; i <= NRAND; i++) begin
         if (i < NRAND) begin
            logic [15:0] ra, rb;
            logic [TAG_W-1:0] rt;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rt = TAG_W'($urandom);
            exp_pair[i] = model(ra, rb);
            exp_tag[i]  = rt;
            drive(1'b1, ra, rb, rt);
         end else begin
            drive(1'b0, 16'h0, 16'h0, 4'd0);
         end
         step();
         if (i >= 1) begin
            check_eq("rnd_valid", 16'(out_valid), 16'd1);
            check_eq("rnd_hi", 16'(pair_hi), 16'(exp_pair[i-1][11:6]));
            check_eq("rnd_lo", 16'(pair_lo), 16'(exp_pair[i-1][5:0]));
            check_eq("rnd_tag", 16'(rd_out), 16'(exp_tag[i-1]));
         end
      end
      drive(1'b0, 16'h0, 16'h0, 4'd0);
      step();

      // Stall: lanes {1,2,3,4}+{1,1,1,1} -> hi=2+3=5, lo=4+5=9.
      drive(1'b1, 16'h1234, 16'h1111, 4'd7);
      step();
      drive(1'b1, 16'hFFFF, 16'hFFFF, 4'd2);
      stall = 1'b1;
      #1;
      check_eq("ready_lo", 16'(in_ready), 16'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stall_valid", 16'(out_valid), 16'd0);
      end
      stall = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 4'd0);
      step();
      check_eq("stall_rel_valid", 16'(out_valid), 16'd1);
      check_eq("stall_rel_hi", 16'(pair_hi), 16'd5);
      check_eq("stall_rel_lo", 16'(pair_lo), 16'd9);
      check_eq("stall_rel_tag", 16'(rd_out), 16'd7);
      stall = 1'b1;
      drive(1'b1, 16'h7777, 16'h7777, 4'd1);
      for (int i = 0; i < 2; i++) begin
         step();
         check_eq("hold_valid", 16'(out_valid), 16'd1);
         check_eq("hold_hi", 16'(pair_hi), 16'd5);
         check_eq("hold_lo", 16'(pair_lo), 16'd9);
      end
      stall = 1'b0;
      drive(1'b0, 16'h0, 16'h0, 4'd0);
      step();
      step();

      // Flush with two ops in flight; run 0 plain, run 1 with stall held.
      for (int run = 0; run < 2; run++) begin
         drive(1'b1, 16'h1111, 16'h1111, 4'd4);  // hi=4, lo=4
         step();
         drive(1'b1, 16'h2222, 16'h1111, 4'd6);
         step();
         check_eq("fl_pre_valid", 16'(out_valid), 16'd1);
         check_eq("fl_pre_hi", 16'(pair_hi), 16'd4);
         drive(1'b1, 16'h3333, 16'h3333, 4'd8);
         flush = 1'b1;
         stall = (run == 1);
         step();
         flush = 1'b0;
         stall = 1'b0;
         drive(1'b0, 16'h0, 16'h0, 4'd0);
         check_eq("fl_valid0", 16'(out_valid), 16'd0);
         if (run == 1) check_eq("fl_stall_hold_hi", 16'(pair_hi), 16'd4);
         step();
         check_eq("fl_valid1", 16'(out_valid), 16'd0);
         step();
         check_eq("fl_valid2", 16'(out_valid), 16'd0);
      end

      // Mid-flight reset, then FFFF+0001: lanes {-1,-1,-1,0} -> hi=-2, lo=-1.
      drive(1'b1, 16'h7777, 16'h7777, 4'd3);
      step();
      drive(1'b1, 16'h1111, 16'h1111, 4'd5);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(1'b0, 16'h0, 16'h0, 4'd0);
      check_eq("mrst_valid", 16'(out_valid), 16'd0);
      check_eq("mrst_hi", 16'(pair_hi), 16'd0);
      check_eq("mrst_lo", 16'(pair_lo), 16'd0);
      check_eq("mrst_tag", 16'(rd_out), 16'd0);
      step();
      check_eq("mrst_drain", 16'(out_valid), 16'd0);
      drive(1'b1, 16'hFFFF, 16'h0001, 4'd2);
      step();
      drive(1'b0, 16'h0, 16'h0, 4'd0);
      step();
      check_eq("post_valid", 16'(out_valid), 16'd1);
      check_eq("post_hi", 16'(pair_hi), 16'h3E);
      check_eq("post_lo", 16'(pair_lo), 16'h3F);
      check_eq("post_tag", 16'(rd_out), 16'd2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
